// File: rtl/dot_pkg.sv
// dot_pkg -- shared definitions for the dot_accum block.
//   state_e : controller states (IDLE, ACCUM, OUTPUT)
//   dot_aw  : accumulator width for given activation/weight MSB indices and
//             term count (product width plus bias headroom plus growth bits)
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    function automatic int dot_aw(input int ip, input int wp, input int n);
        return ip + wp + 3 + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_sat.sv
// dot_sat -- combinational output conditioning for the dot product.
//   acc  : in,  AW signed   full-precision accumulator value
//   relu : in,  1           clamp negative results to zero
//   data : out, IP+1 signed (acc >>> SHIFT) saturated to [-2^IP, 2^IP-1]
//   sat  : out, 1           data was clamped (never set when ReLU zeroes)
module dot_sat #(
    parameter int IP    = 8,
    parameter int AW    = 21,
    parameter int SHIFT = 0
) (
    input  logic signed [AW-1:0] acc,
    input  logic                 relu,
    output logic signed [IP:0]   data,
    output logic                 sat
);

    localparam logic signed [AW-1:0] MAX_V = {{(AW-IP){1'b0}}, {IP{1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

    // Returns {sat, data}; ReLU takes priority so a negative result is
    // reported as a clean zero rather than a saturated negative value.
    function automatic logic [IP+1:0] shape(input logic signed [AW-1:0] s,
                                            input logic relu_f);
        logic [IP+1:0] r;
        if (relu_f && s[AW-1]) begin
            r = '0;
        end else if (s > MAX_V) begin
            r = {1'b1, MAX_V[IP:0]};
        end else if (s < MIN_V) begin
            r = {1'b1, MIN_V[IP:0]};
        end else begin
            r = {1'b0, s[IP:0]};
        end
        return r;
    endfunction

    logic signed [AW-1:0] shifted;
    logic [IP+1:0]        res;

    assign shifted = acc >>> SHIFT;
    assign res     = shape(shifted, relu);
    assign sat     = res[IP+1];
    assign data    = $signed(res[IP:0]);

endmodule

// File: rtl/dot_accum.sv
// dot_accum -- streaming signed dot-product accumulator with bias, shift,
// saturation and optional ReLU.
//   clk, rst            : clock; asynchronous active-high reset
//   in_valid/in_ready   : term handshake (activation in_data, weight in_w)
//   in_bias, relu_en    : sampled with the first term of each vector
//   out_valid/out_ready : result handshake
//   out_data            : shifted, saturated, optionally ReLU'd result
//   out_acc             : full-precision accumulator
//   out_sat             : out_data was clamped
// One vector is N accepted terms; the result appears the cycle after the
// Nth accept and is held until out_ready. No term is accepted while a
// result is pending, giving one bubble cycle per vector.
module dot_accum
    import dot_pkg::*;
#(
    parameter  int IP    = 8,
    parameter  int WP    = 8,
    parameter  int N     = 16,
    parameter  int SHIFT = 0,
    localparam int AW    = dot_aw(IP, WP, N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [IP:0]    in_data,
    input  logic signed [WP:0]    in_w,
    input  logic signed [IP+WP:0] in_bias,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [IP:0]    out_data,
    output logic signed [AW-1:0]  out_acc,
    output logic                  out_sat
);

    localparam int             CW  = $clog2(N + 1);
    localparam logic [CW-1:0]  N_C = CW'(N);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 relu_q, relu_d;
    logic signed [IP:0]   out_data_q, out_data_d;
    logic signed [AW-1:0] out_acc_q, out_acc_d;
    logic                 out_sat_q, out_sat_d;

    logic                    accept;
    logic                    load_out;
    logic signed [IP+WP+1:0] prod;
    logic signed [AW-1:0]    prod_ext, bias_ext;
    logic signed [IP:0]      sat_data;
    logic                    sat_flag;

    // Full-width signed product: -2^IP * -2^WP needs the extra MSB.
    assign prod     = in_data * in_w;
    assign prod_ext = AW'(prod);
    assign bias_ext = AW'(in_bias);
    assign cnt_inc  = cnt_q + CW'(1);

    assign in_ready  = (state_q != OUTPUT);
    assign out_valid = (state_q == OUTPUT);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        relu_d  = relu_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = bias_ext + prod_ext;
                    cnt_d   = CW'(1);
                    relu_d  = relu_en;
                    state_d = (N == 1) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_C) begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output conditioning works on the value being committed this cycle so
    // the registered result is ready the cycle after the last term.
    dot_sat #(
        .IP    (IP),
        .AW    (AW),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc  (acc_d),
        .relu (relu_d),
        .data (sat_data),
        .sat  (sat_flag)
    );

    assign load_out = (state_d == OUTPUT) && (state_q != OUTPUT);

    always_comb begin
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        out_sat_d  = out_sat_q;
        if (load_out) begin
            out_data_d = sat_data;
            out_acc_d  = acc_d;
            out_sat_d  = sat_flag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_acc_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_data = out_data_q;
    assign out_acc  = out_acc_q;
    assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_dot_accum.sv
module tb_dot_accum;

    localparam int IP    = 8;
    localparam int WP    = 8;
    localparam int N     = 4;
    localparam int SHIFT = 0;
    localparam int AW    = IP + WP + 3 + 2;   // clog2(4) = 2

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [IP:0]    in_data;
    logic signed [WP:0]    in_w;
    logic signed [IP+WP:0] in_bias;
    logic                  relu_en;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [IP:0]    out_data;
    logic signed [AW-1:0]  out_acc;
    logic                  out_sat;

    dot_accum #(.IP(IP), .WP(WP), .N(N), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_w      (in_w),
        .in_bias   (in_bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_acc   (out_acc),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   td[N];
    int   tw[N];
    int   tbias;
    logic trelu;
    int   max_gap;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference: bias plus plain integer sum of products, then floor shift,
    // clamp to the output range, ReLU on negative.
    function automatic longint model_acc();
        longint a = tbias;
        for (int i = 0; i < N; i++) a += longint'(td[i]) * longint'(tw[i]);
        return a;
    endfunction

    task automatic model_out(input longint a, input logic relu,
                             output longint d, output logic s);
        longint v = a >>> SHIFT;
        longint hi = (longint'(1) <<< IP) - 1;
        longint lo = -(longint'(1) <<< IP);
        if (relu && v < 0) begin d = 0;  s = 1'b0; end
        else if (v > hi)   begin d = hi; s = 1'b1; end
        else if (v < lo)   begin d = lo; s = 1'b1; end
        else               begin d = v;  s = 1'b0; end
    endtask

    // Starts and ends just after a falling edge.
    task automatic send_vector(input string tag);
        int to;
        for (int k = 0; k < N; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = td[k][IP:0];
            in_w     = tw[k][WP:0];
            in_bias  = tbias[IP+WP:0];
            relu_en  = trelu;
            to = 0;
            while (!in_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) chk({tag, "_in_ready_timeout"}, in_ready, 1);
            if (k == N - 1) chk({tag, "_early_valid"}, out_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, out_valid, 1);
    endtask

    task automatic get_result(input string tag, input longint ea,
                              input longint ed, input logic es,
                              input int hold);
        int to = 0;
        while (!out_valid && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk({tag, "_out_valid_timeout"}, out_valid, 1);
        repeat (hold) @(negedge clk);
        chk({tag, "_acc"}, out_acc, ea);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_sat"}, out_sat, es);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    task automatic load(input int d0, input int d1, input int d2, input int d3,
                        input int w, input int b, input logic r);
        td[0] = d0; td[1] = d1; td[2] = d2; td[3] = d3;
        for (int i = 0; i < N; i++) tw[i] = w;
        tbias = b;
        trelu = r;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_acc"}, out_acc, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_sat"}, out_sat, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ea, ed;
        logic   es;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_w = '0; in_bias = '0;
        relu_en = 1'b0; out_ready = 1'b0; max_gap = 0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        // Basic vector with bias
        load(1, 2, 3, 4, 2, 5, 1'b0);
        send_vector("basic");
        get_result("basic", 25, 25, 1'b0, 0);

        // Positive saturation
        load(255, 255, 255, 255, 255, 0, 1'b0);
        send_vector("pos_sat");
        get_result("pos_sat", 260100, 255, 1'b1, 0);

        // Negative saturation, then the same with ReLU
        load(-256, -256, -256, -256, 255, 0, 1'b0);
        send_vector("neg_sat");
        get_result("neg_sat", -261120, -256, 1'b1, 0);
        load(-256, -256, -256, -256, 255, 0, 1'b1);
        send_vector("neg_relu");
        get_result("neg_relu", -261120, 0, 1'b0, 0);

        // Largest products plus large bias: exact, no wrap
        load(-256, -256, -256, -256, -256, 65535, 1'b0);
        send_vector("max_prod");
        get_result("max_prod", 327679, 255, 1'b1, 0);

        // Back-pressure hold; next vector's first term offered throughout
        load(1, 2, 3, 4, 3, 0, 1'b0);
        send_vector("hold");
        in_valid = 1'b1; in_data = 9'sd1; in_w = 9'sd2; in_bias = 17'sd5;
        relu_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_acc", out_acc, 30);
            chk("hold_data", out_data, 30);
            chk("hold_sat", out_sat, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        load(1, 2, 3, 4, 2, 5, 1'b0);
        send_vector("after_bubble");
        get_result("after_bubble", 25, 25, 1'b0, 0);

        // Reset in the middle of a vector
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 9'sd7; in_w = 9'sd9; in_bias = 17'sd100;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        load(1, 1, 1, 1, 1, 0, 1'b0);
        send_vector("post_abort");
        get_result("post_abort", 4, 4, 1'b0, 0);

        // Reset while a result is pending
        load(5, 6, 7, 8, 1, 0, 1'b0);
        send_vector("pend");
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("pend_rst");
        rst = 1'b0;
        @(negedge clk);
        load(1, 1, 1, 1, 1, 0, 1'b0);
        send_vector("post_pend");
        get_result("post_pend", 4, 4, 1'b0, 0);

        // Randomized vectors with gaps and output back-pressure
        max_gap = 2;
        for (int v = 0; v < 30; v++) begin
            for (int i = 0; i < N; i++) begin
                td[i] = int'($urandom_range(0, 511)) - 256;
                tw[i] = int'($urandom_range(0, 511)) - 256;
            end
            if (v % 3 == 0) begin
                for (int i = 0; i < N; i++) tw[i] = int'($urandom_range(0, 4)) - 2;
            end
            tbias = int'($urandom_range(0, 131071)) - 65536;
            if (v % 3 == 1) tbias = int'($urandom_range(0, 600)) - 300;
            trelu = 1'($urandom_range(0, 1));
            ea = model_acc();
            model_out(ea, trelu, ed, es);
            send_vector("rand");
            get_result("rand", ea, ed, es, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 SHALL have parameter IP, default 8; MSB index of activation and output data (width IP+1).
REQ-002 SHALL have parameter WP, default 8; MSB index of weight (width WP+1).
REQ-003 SHALL have parameter N, default 16; number of terms per dot product, N >= 1.
REQ-004 SHALL have parameter SHIFT, default 0; arithmetic right shift applied before output saturation.
REQ-005 SHALL have local parameter AW = IP+WP+3+clog2(N); accumulator width.
REQ-006 SHALL have port clk, input, 1; the only clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1; term offered.
REQ-009 SHALL have port in_ready, output, 1; term may be accepted.
REQ-010 SHALL have port in_data, input, IP+1 signed; activation.
REQ-011 SHALL have port in_w, input, WP+1 signed; weight.
REQ-012 SHALL have port in_bias, input, IP+WP+1 signed; bias, sampled only with the first term of a vector.
REQ-013 SHALL have port relu_en, input, 1; sampled with the first term and held for the vector.
REQ-014 SHALL have port out_valid, output, 1; result available.
REQ-015 SHALL have port out_ready, input, 1; consumer accepts the result.
REQ-016 SHALL have port out_data, output, IP+1 signed; shifted, saturated, optionally ReLU'd result.
REQ-017 SHALL have port out_acc, output, AW signed; full-precision accumulator.
REQ-018 SHALL have port out_sat, output, 1; out_data was clamped.

Function
REQ-019 SHALL accept a term when in_valid && in_ready are high on a rising clk edge.
REQ-020 SHALL implement FSM states IDLE, ACCUM and OUTPUT; in_ready = 1 in IDLE and ACCUM and 0 in OUTPUT; out_valid = 1 only in OUTPUT.
REQ-021 SHALL, on an accept in IDLE: set acc = sext(in_bias) + in_data*in_w and cnt = 1, latch relu_en, then go to ACCUM (or to OUTPUT if N == 1).
REQ-022 SHALL, on an accept in ACCUM: set acc += in_data*in_w and cnt += 1, and go to OUTPUT when that accept is term N.
REQ-023 SHALL compute each product at full width IP+WP+2 signed, with no truncation (-256*-256 = 65536 exact), sign-extended to AW.
REQ-024 SHALL assert out_valid the cycle after the Nth accept; latency is 1 cycle after the last term.
REQ-025 SHALL hold out_data, out_acc and out_sat stable while out_valid && !out_ready.
REQ-026 SHALL go from OUTPUT to IDLE on out_ready; a new vector SHALL NOT be accepted in the same cycle, so there is exactly one bubble per vector.
REQ-027 SHALL derive out_data from s = out_acc >>> SHIFT (floor), clamped to [-2^IP, 2^IP-1]; out_sat = 1 when clamping occurred.
REQ-028 SHALL force out_data = 0 and out_sat = 0 when the latched relu_en is set and s < 0.
REQ-029 SHALL keep state unchanged when in_valid is low in ACCUM; gaps between terms are allowed.
REQ-030 SHALL register out_data, out_acc and out_sat, updating them only on entry to OUTPUT.

Reset
REQ-031 SHALL, while rst is high: set state = IDLE, cnt = 0, acc = 0, out_valid = 0, out_data = 0, out_acc = 0 and out_sat = 0.
REQ-032 SHALL discard a partially accumulated vector or a pending output when rst is asserted, and start the next vector cleanly after rst deasserts.
REQ-033 SHALL have in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE, ACCUM, OUTPUT) and the AW width function in a shared package dot_pkg.
REQ-035 SHALL implement shift, saturate and ReLU in a combinational sub-module dot_sat (parameters IP, AW, SHIFT).

Verification (N=4, SHIFT=0, IP=WP=8)
REQ-036 SHALL cover: in_data 1,2,3,4 with in_w 2 each, bias 5, relu 0 -> out_acc 25, out_data 25, out_sat 0, out_valid 1 cycle after the 4th accept.
REQ-037 SHALL cover: in_data 255 with in_w 255 x4, bias 0 -> out_acc 260100, out_data 255, out_sat 1.
REQ-038 SHALL cover: in_data -256 with in_w 255 x4, bias 0 -> out_acc -261120, out_data -256, out_sat 1; the same with relu 1 -> out_data 0, out_sat 0.
REQ-039 SHALL cover: in_data -256 with in_w -256 x4, bias 65535 -> out_acc 327679 exact, with no wrap.
REQ-040 SHALL cover: out_ready low for 5 cycles -> out_valid held, outputs stable, in_ready 0; then out_ready high -> IDLE and the next vector accepted after 1 bubble.
REQ-041 SHALL cover: rst pulse after 2 terms, then vector 1,1,1,1 with in_w 1 and bias 0 -> out_acc 4, with no residue from the aborted vector.
